// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin synchroniser, clock glitch filter and 11-bit odd-parity frame decoder
// with an inter-strobe timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err_parity,
    output logic       err_frame
);

    localparam int              TO_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 2);
    localparam logic [3:0]      FILT_LAST = 4'(FILTER_LEN - 1);

    logic [1:0]      clk_sync_reg, data_sync_reg;
    logic            filt_reg, filt_d_reg, strobe_reg, data_bit_reg;
    logic [3:0]      filt_cnt_reg;
    frame_state_t    state_reg, state_next;
    logic [2:0]      bitcnt_reg;
    logic [7:0]      shift_reg, rx_byte_reg;
    logic            par_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            byte_valid_reg, err_parity_reg, err_frame_reg;
    logic            timeout_hit, frame_done;
    logic            byte_ok_next, err_parity_next, err_frame_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            filt_reg      <= 1'b1;
            filt_d_reg    <= 1'b1;
            filt_cnt_reg  <= '0;
            strobe_reg    <= 1'b0;
            data_bit_reg  <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            filt_d_reg    <= filt_reg;
            strobe_reg    <= filt_d_reg & ~filt_reg;
            if (filt_d_reg & ~filt_reg)
                data_bit_reg <= data_sync_reg[1];
            // Level only flips after FILTER_LEN consecutive disagreeing samples
            if (clk_sync_reg[1] != filt_reg) begin
                if (filt_cnt_reg == FILT_LAST) begin
                    filt_reg     <= clk_sync_reg[1];
                    filt_cnt_reg <= '0;
                end else begin
                    filt_cnt_reg <= filt_cnt_reg + 4'd1;
                end
            end else begin
                filt_cnt_reg <= '0;
            end
        end
    end

    // Counter is 0 the cycle after a strobe, so TIMEOUT-2 puts err_frame TIMEOUT cycles after it
    assign timeout_hit = (state_reg != IDLE) && !strobe_reg && (to_cnt_reg == TO_LAST);
    assign frame_done  = strobe_reg && (state_reg == STOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (timeout_hit) begin
            state_next = IDLE;
        end else if (strobe_reg) begin
            case (state_reg)
                IDLE:    if (!data_bit_reg) state_next = DATA;
                DATA:    if (bitcnt_reg == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        byte_ok_next    = frame_done && data_bit_reg && (^{shift_reg, par_reg});
        err_parity_next = frame_done && data_bit_reg && !(^{shift_reg, par_reg});
        err_frame_next  = (frame_done && !data_bit_reg) || timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitcnt_reg     <= '0;
            shift_reg      <= '0;
            par_reg        <= 1'b0;
            rx_byte_reg    <= '0;
            to_cnt_reg     <= '0;
            byte_valid_reg <= 1'b0;
            err_parity_reg <= 1'b0;
            err_frame_reg  <= 1'b0;
        end else begin
            byte_valid_reg <= byte_ok_next;
            err_parity_reg <= err_parity_next;
            err_frame_reg  <= err_frame_next;
            if (state_reg == IDLE || strobe_reg) to_cnt_reg <= '0;
            else                                 to_cnt_reg <= to_cnt_reg + 1'b1;
            if (strobe_reg) begin
                case (state_reg)
                    IDLE:   bitcnt_reg <= '0;
                    DATA: begin
                        shift_reg  <= {data_bit_reg, shift_reg[7:1]};
                        bitcnt_reg <= bitcnt_reg + 3'd1;
                    end
                    PARITY: par_reg <= data_bit_reg;
                    STOP:   rx_byte_reg <= shift_reg;
                    default: ;
                endcase
            end
        end
    end

    assign byte_valid = byte_valid_reg;
    assign rx_byte    = rx_byte_reg;
    assign err_parity = err_parity_reg;
    assign err_frame  = err_frame_reg;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into key events and queues them in a FIFO.
// Define PS2_RX_ERR_CNT_EN to add the saturating err_cnt output.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
`ifdef PS2_RX_ERR_CNT_EN
   ,output logic [7:0] err_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             byte_valid;
    logic [7:0]       rx_byte;
    logic             ext_reg, brk_reg, overflow_reg;
    logic             push_req, push, pop, full;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    ps2_evt_t         mem [FIFO_DEPTH];
    ps2_evt_t         head, new_evt;

    ps2_frame_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_frame (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .err_parity(err_parity),
        .err_frame (err_frame)
    );

    assign push_req = byte_valid && (rx_byte != PS2_EXT_PREFIX) && (rx_byte != PS2_BRK_PREFIX);
    assign new_evt  = '{code: rx_byte, ext: ext_reg, brk: brk_reg};
    assign evt_valid = (count_reg != '0);
    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop      = evt_valid && evt_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (err_parity || err_frame) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == PS2_EXT_PREFIX) begin
                ext_reg <= 1'b1;
            end else if (rx_byte == PS2_BRK_PREFIX) begin
                brk_reg <= 1'b1;
            end else begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= new_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= push_req && full && !pop;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head     = mem[rd_ptr_reg];
    assign evt_code = evt_valid ? head.code : 8'h00;
    assign evt_ext  = evt_valid & head.ext;
    assign evt_brk  = evt_valid & head.brk;
    assign overflow = overflow_reg;

`ifdef PS2_RX_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt_reg <= '0;
        else if ((err_parity || err_frame || overflow_reg) && (err_cnt_reg != 8'hFF))
            err_cnt_reg <= err_cnt_reg + 8'd1;
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule
